// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-side arbiter and its FIFO.
// Default sizes live here so the arbiter and the FIFO agree on width and depth.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_WIDTH     = 128;
  localparam int DEF_MAX_BURST = 8;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid requester at or after ptr,
// wrapping modulo NUM_REQ. Shared with read-side schedulers.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      idx,
  output logic               any
);

  // Walk offsets from farthest to nearest so the nearest valid one wins last.
  always_comb begin
    idx = '0;
    any = |valid;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid[(int'(ptr) + k) % NUM_REQ]) idx = IW'((int'(ptr) + k) % NUM_REQ);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// One owner at a time, bursts bounded by MAX_BURST beats or the owner's last flag.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int IW        = $clog2(NUM_REQ),
  parameter int BW        = $clog2(MAX_BURST + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_wr,
  output logic [WIDTH-1:0]           fifo_data_in,
  output logic [IW-1:0]              grant_id,
  output logic                       busy
);

  arb_state_e                        state, state_nxt;
  logic [IW-1:0]                     owner, owner_nxt;
  logic [IW-1:0]                     rr_ptr, rr_ptr_nxt;
  logic [BW-1:0]                     beat_cnt, beat_cnt_nxt;
  logic [IW-1:0]                     pick_idx;
  logic                              pick_any;
  logic                              beat, burst_end;
  logic [NUM_REQ-1:0][WIDTH-1:0]     data_arr;

  assign data_arr = req_data;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Handshake is purely combinational so the FIFO and the producer see the same edge.
  always_comb begin
    req_ready    = '0;
    beat         = 1'b0;
    burst_end    = 1'b0;
    fifo_wr      = 1'b0;
    fifo_data_in = '0;
    if (state == BURST) begin
      req_ready[owner] = !fifo_full;
      beat             = req_valid[owner] && !fifo_full;
      burst_end        = beat && (req_last[owner] || beat_cnt == BW'(MAX_BURST - 1));
      fifo_wr          = beat;
      if (beat) fifo_data_in = data_arr[owner];
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt    = BURST;
          owner_nxt    = pick_idx;
          beat_cnt_nxt = '0;
        end
      end
      BURST: begin
        if (beat) beat_cnt_nxt = beat_cnt + BW'(1);
        if (burst_end) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign grant_id = owner;
  assign busy     = (state == BURST);

  a_no_wr_when_full: assert property (@(posedge clk) disable iff (reset) fifo_wr |-> !fifo_full);
  a_ready_onehot0:   assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed vector table, corner-case
// sequences, and randomized traffic against a transaction-level reference model.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MB = 8;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N*W-1:0]   req_data = '0;
  logic [N-1:0]     req_last = '0;
  logic [N-1:0]     req_ready;
  logic             fifo_full = 1'b0;
  logic             fifo_wr;
  logic [W-1:0]     fifo_data_in;
  logic [IW-1:0]    grant_id;
  logic             busy;

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr(fifo_wr), .fifo_data_in(fifo_data_in), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pat(int i, int c);
    return W'(32'hA000_0000 | (i << 16) | (c & 16'hFFFF));
  endfunction

  task automatic set_data(int c);
    for (int i = 0; i < N; i++) req_data[i*W +: W] = pat(i, c);
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = '0; req_last = '0; fifo_full = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0]  v;
    logic [N-1:0]  l;
    logic          f;
    logic [N-1:0]  rdy;
    logic          wr;
    logic [IW-1:0] gid;
    logic          busy;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(logic [N-1:0] v, logic [N-1:0] l, logic f,
                              logic [N-1:0] rdy, logic wr, logic [IW-1:0] gid, logic b);
    vec_t r;
    r.v = v; r.l = l; r.f = f; r.rdy = rdy; r.wr = wr; r.gid = gid; r.busy = b;
    return r;
  endfunction

  // Reference model state: who owns the port, where the rotation points, beats done.
  bit m_active;
  int m_owner, m_ptr, m_beats;

  task automatic model_reset();
    m_active = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
  endtask

  initial begin
    int k, cur_run, r3_writes, remaining, wrs;
    int runs[$];
    logic [N-1:0] e_rdy;
    logic e_wr;
    logic [W-1:0] e_data;

    // Directed table: single 3-beat burst, full stall, rotation, owner-valid drop.
    tbl[0]  = mk(4'b0001, 4'b0000, 0, 4'b0000, 0, 0, 0);
    tbl[1]  = mk(4'b0001, 4'b0000, 0, 4'b0001, 1, 0, 1);
    tbl[2]  = mk(4'b0001, 4'b0000, 0, 4'b0001, 1, 0, 1);
    tbl[3]  = mk(4'b0001, 4'b0001, 0, 4'b0001, 1, 0, 1);
    tbl[4]  = mk(4'b0011, 4'b0000, 0, 4'b0000, 0, 0, 0);
    tbl[5]  = mk(4'b0011, 4'b0000, 1, 4'b0000, 0, 1, 1);
    tbl[6]  = mk(4'b0011, 4'b0010, 0, 4'b0010, 1, 1, 1);
    tbl[7]  = mk(4'b0001, 4'b0000, 0, 4'b0000, 0, 1, 0);
    tbl[8]  = mk(4'b0100, 4'b0000, 0, 4'b0001, 0, 0, 1);
    tbl[9]  = mk(4'b0101, 4'b0001, 0, 4'b0001, 1, 0, 1);
    tbl[10] = mk(4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0);
    tbl[11] = mk(4'b0010, 4'b0000, 0, 4'b0000, 0, 0, 0);

    // Reset state
    #2;
    chk("rst_ready", 64'(req_ready), 0);
    chk("rst_wr", 64'(fifo_wr), 0);
    chk("rst_data", 64'(fifo_data_in), 0);
    chk("rst_gid", 64'(grant_id), 0);
    chk("rst_busy", 64'(busy), 0);
    do_reset();

    for (int s = 0; s < 12; s++) begin
      if (s != 0) @(negedge clk);
      req_valid = tbl[s].v; req_last = tbl[s].l; fifo_full = tbl[s].f;
      set_data(s);
      #1;
      chk($sformatf("tbl%0d_ready", s), 64'(req_ready), 64'(tbl[s].rdy));
      chk($sformatf("tbl%0d_wr", s), 64'(fifo_wr), 64'(tbl[s].wr));
      chk($sformatf("tbl%0d_gid", s), 64'(grant_id), 64'(tbl[s].gid));
      chk($sformatf("tbl%0d_busy", s), 64'(busy), 64'(tbl[s].busy));
      chk($sformatf("tbl%0d_data", s), 64'(fifo_data_in),
          tbl[s].wr ? 64'(pat(int'(tbl[s].gid), s)) : 64'd0);
    end

    // Full for 5 cycles mid-burst: held beat written once full drops, none lost.
    do_reset();
    k = 0; wrs = 0;
    for (int c = 0; c < 16; c++) begin
      if (c != 0) @(negedge clk);
      fifo_full = (c >= 3 && c < 8);
      req_valid = (k < 4) ? 4'b0001 : 4'b0000;
      req_last  = (k == 3) ? 4'b0001 : 4'b0000;
      set_data(k);
      #1;
      if (fifo_full) begin
        chk("full_wr", 64'(fifo_wr), 0);
        chk("full_ready", 64'(req_ready), 0);
      end
      if (c == 8) chk("full_resume_wr", 64'(fifo_wr), 1);
      if (fifo_wr) begin
        chk("full_data", 64'(fifo_data_in), 64'(pat(0, k)));
        k++; wrs++;
      end
    end
    chk("full_beats", 64'(wrs), 4);

    // Requester 2 streams 20 beats without last; requester 3 sends single beats.
    do_reset();
    remaining = 20; cur_run = 0; r3_writes = 0; runs.delete();
    for (int c = 0; c < 80 && remaining > 0; c++) begin
      if (c != 0) @(negedge clk);
      req_valid = {1'b1, 1'b1, 2'b00};
      req_last  = {1'b1, remaining == 1, 2'b00};
      set_data(20 - remaining);
      #1;
      if (fifo_wr && grant_id == 2) begin
        cur_run++; remaining--;
        if (remaining == 0) runs.push_back(cur_run);
      end else if (cur_run > 0) begin
        runs.push_back(cur_run); cur_run = 0;
      end
      if (fifo_wr && grant_id == 3 && runs.size() > 0 && remaining > 0) r3_writes++;
    end
    chk("mb_done", 64'(remaining), 0);
    chk("mb_nruns", 64'(runs.size()), 3);
    if (runs.size() == 3) begin
      chk("mb_run0", 64'(runs[0]), 8);
      chk("mb_run1", 64'(runs[1]), 8);
      chk("mb_run2", 64'(runs[2]), 4);
    end
    chk("mb_r3_between", 64'(r3_writes), 2);

    // Reset pulsed on beat 4 of a burst from requester 1.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c != 0) @(negedge clk);
      req_valid = 4'b0010; req_last = '0; set_data(c);
      #1;
    end
    chk("rstmid_pre_wr", 64'(fifo_wr), 1);
    reset = 1'b1;
    #1;
    chk("rstmid_wr", 64'(fifo_wr), 0);
    chk("rstmid_ready", 64'(req_ready), 0);
    chk("rstmid_busy", 64'(busy), 0);
    chk("rstmid_data", 64'(fifo_data_in), 0);
    @(negedge clk);
    reset = 1'b0; req_valid = 4'b1111;
    #1;
    chk("rstmid_idle", 64'(busy), 0);
    @(negedge clk);
    #1;
    chk("rstmid_busy2", 64'(busy), 1);
    chk("rstmid_gid", 64'(grant_id), 0);

    // Randomized traffic against the transaction-level model.
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      if (c != 0) @(negedge clk);
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        req_last[i]  = ($urandom_range(0, 3) == 0);
        req_data[i*W +: W] = $urandom;
      end
      fifo_full = ($urandom_range(0, 4) == 0);
      #1;
      e_rdy = '0; e_wr = 0; e_data = '0;
      if (m_active) begin
        if (!fifo_full) e_rdy[m_owner] = 1'b1;
        e_wr = req_valid[m_owner] && !fifo_full;
        if (e_wr) e_data = req_data[m_owner*W +: W];
      end
      checks++;
      if (req_ready !== e_rdy || fifo_wr !== e_wr || fifo_data_in !== e_data ||
          grant_id !== IW'(m_owner) || busy !== m_active) begin
        errors++;
        $display("FAIL rand c=%0d: rdy %b/%b wr %b/%b data %h/%h gid %0d/%0d busy %b/%b",
                 c, req_ready, e_rdy, fifo_wr, e_wr, fifo_data_in, e_data,
                 grant_id, m_owner, busy, m_active);
      end
      // Advance model by one clock.
      if (!m_active) begin
        for (int o = N - 1; o >= 0; o--)
          if (req_valid[(m_ptr + o) % N]) begin
            m_owner = (m_ptr + o) % N; m_active = 1; m_beats = 0;
          end
      end else if (e_wr) begin
        m_beats++;
        if (req_last[m_owner] || m_beats == MB) begin
          m_active = 0;
          m_ptr = (m_owner + 1) % N;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
